// File: rtl/extremum_tree.sv
// extremum_tree: pipelined signed min/max reduction over NUM_INPUTS
// activation-gated candidates, one register stage per tree level.
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous, active-high reset
//   in_valid          candidate vector on this cycle is processed
//   mode              0 = maximum, 1 = minimum (travels with the data)
//   numbers           candidate i at [i*WIDTH +: WIDTH], signed
//   activations       bit i set = candidate i takes part
//   out_valid         result outputs valid this cycle
//   result            signed extremum (0 when nothing was active)
//   result_activation at least one candidate was active
//   result_index      index of the winning candidate
//   result_mode       mode that produced this result
//
// Latency is L = ceil(log2(NUM_INPUTS)) cycles, throughput one vector
// per clock, no backpressure.

module extremum_tree #(
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 8,
    parameter int IDX_W      = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic                          mode,
    input  logic [NUM_INPUTS*WIDTH-1:0]   numbers,
    input  logic [NUM_INPUTS-1:0]         activations,
    output logic                          out_valid,
    output logic signed [WIDTH-1:0]       result,
    output logic                          result_activation,
    output logic [IDX_W-1:0]              result_index,
    output logic                          result_mode
);

    // Tree depth and padded leaf count.
    localparam int L = $clog2(NUM_INPUTS);
    localparam int P = 1 << L;

    // Level 0 is the (padded) combinational leaf layer; levels 1..L
    // are registered. Level l holds P >> l nodes.
    for (genvar l = 0; l <= L; l++) begin : g_lvl
        localparam int N = P >> l;

        logic [N*WIDTH-1:0] val;
        logic [N-1:0]       act;
        logic [N*IDX_W-1:0] idx;
        logic               md;
        logic               vld;

        if (l == 0) begin : g_leaf
            assign md  = mode;
            assign vld = in_valid;

            for (genvar i = 0; i < P; i++) begin : g_in
                if (i < NUM_INPUTS) begin : g_real
                    assign val[i*WIDTH +: WIDTH] =
                        numbers[i*WIDTH +: WIDTH];
                    assign act[i] = activations[i];
                    assign idx[i*IDX_W +: IDX_W] = IDX_W'(i);
                end else begin : g_pad
                    // Padding leaves can never win.
                    assign val[i*WIDTH +: WIDTH] = '0;
                    assign act[i] = 1'b0;
                    assign idx[i*IDX_W +: IDX_W] = '0;
                end
            end
        end else begin : g_node
            logic [N*WIDTH-1:0] val_d;
            logic [N-1:0]       act_d;
            logic [N*IDX_W-1:0] idx_d;

            for (genvar n = 0; n < N; n++) begin : g_cmp
                logic signed [WIDTH-1:0] a_v;
                logic signed [WIDTH-1:0] b_v;
                logic                    a_act;
                logic                    b_act;
                logic [IDX_W-1:0]        a_i;
                logic [IDX_W-1:0]        b_i;
                logic                    any;
                logic                    take_b;

                // Left child a always carries the lower index.
                assign a_v   = g_lvl[l-1].val[(2*n)*WIDTH +: WIDTH];
                assign b_v   = g_lvl[l-1].val[(2*n+1)*WIDTH +: WIDTH];
                assign a_act = g_lvl[l-1].act[2*n];
                assign b_act = g_lvl[l-1].act[2*n+1];
                assign a_i   = g_lvl[l-1].idx[(2*n)*IDX_W +: IDX_W];
                assign b_i   = g_lvl[l-1].idx[(2*n+1)*IDX_W +: IDX_W];
                assign any   = a_act | b_act;

                // Strict compares so a tie keeps the lower index.
                always_comb begin
                    take_b = 1'b0;
                    unique case ({a_act, b_act})
                        2'b11: begin
                            if (g_lvl[l-1].md)
                                take_b = (b_v < a_v);
                            else
                                take_b = (b_v > a_v);
                        end
                        2'b01:   take_b = 1'b1;
                        default: take_b = 1'b0;
                    endcase
                end

                assign act_d[n] = any;

                // Nothing active forces a clean zero value and index.
                assign val_d[n*WIDTH +: WIDTH] =
                    !any   ? '0  :
                    take_b ? b_v : a_v;

                assign idx_d[n*IDX_W +: IDX_W] =
                    !any   ? '0  :
                    take_b ? b_i : a_i;
            end

            // Data only loads with a valid vector; bubbles leave the
            // previous contents in place behind a cleared valid bit.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld <= 1'b0;
                    md  <= 1'b0;
                    val <= '0;
                    act <= '0;
                    idx <= '0;
                end else begin
                    vld <= g_lvl[l-1].vld;
                    if (g_lvl[l-1].vld) begin
                        md  <= g_lvl[l-1].md;
                        val <= val_d;
                        act <= act_d;
                        idx <= idx_d;
                    end
                end
            end
        end
    end

    // The root node is the single registered result.
    assign out_valid         = g_lvl[L].vld;
    assign result            = g_lvl[L].val;
    assign result_activation = g_lvl[L].act[0];
    assign result_index      = g_lvl[L].idx;
    assign result_mode       = g_lvl[L].md;

endmodule

// File: tb/tb_extremum_tree.sv
// tb_extremum_tree: directed vector table plus streaming, reset and
// odd-size random checks for extremum_tree.

module tb_extremum_tree;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    // 8 x 8-bit instance
    logic        in_valid8;
    logic        mode8;
    logic [63:0] numbers8;
    logic [7:0]  act8;
    logic        ov8;
    logic [7:0]  res8;
    logic        ract8;
    logic [2:0]  ridx8;
    logic        rmode8;

    // 5 x 4-bit instance
    logic        in_valid5;
    logic        mode5;
    logic [19:0] numbers5;
    logic [4:0]  act5;
    logic        ov5;
    logic [3:0]  res5;
    logic        ract5;
    logic [2:0]  ridx5;
    logic        rmode5;

    extremum_tree #(.WIDTH(8), .NUM_INPUTS(8)) u_dut8 (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid8),
        .mode             (mode8),
        .numbers          (numbers8),
        .activations      (act8),
        .out_valid        (ov8),
        .result           (res8),
        .result_activation(ract8),
        .result_index     (ridx8),
        .result_mode      (rmode8)
    );

    extremum_tree #(.WIDTH(4), .NUM_INPUTS(5)) u_dut5 (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid5),
        .mode             (mode5),
        .numbers          (numbers5),
        .activations      (act5),
        .out_valid        (ov5),
        .result           (res5),
        .result_activation(ract5),
        .result_index     (ridx5),
        .result_mode      (rmode5)
    );

    typedef struct {
        int         n [8];
        logic [7:0] a;
        logic       m;
        int         r;
        logic       ra;
        int         ri;
    } vec_t;

    typedef struct {
        logic v;
        int   r;
        logic ra;
        int   ri;
        logic m;
    } exp_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d",
                     name, $signed(got), got, $signed(exp));
        end
    endtask

    // Plain linear scan: first strictly better candidate wins.
    function automatic void model(input int n [8], input int cnt,
                                  input logic [7:0] a, input logic m,
                                  output int r, output logic ra,
                                  output int ri);
        r  = 0;
        ra = 1'b0;
        ri = 0;
        for (int i = 0; i < cnt; i++) begin
            if (a[i]) begin
                if (!ra || (m ? (n[i] < r) : (n[i] > r))) begin
                    r  = n[i];
                    ri = i;
                    ra = 1'b1;
                end
            end
        end
    endfunction

    task automatic drive8(input int n [8], input logic [7:0] a,
                          input logic m);
        for (int i = 0; i < 8; i++)
            numbers8[i*8 +: 8] = 8'(n[i]);
        act8      = a;
        mode8     = m;
        in_valid8 = 1'b1;
    endtask

    task automatic chk8(input string tag, input int r,
                        input logic ra, input int ri, input logic m);
        chk({tag, "_ov"},   {31'd0, ov8},    1);
        chk({tag, "_res"},  $signed(res8),   r);
        chk({tag, "_act"},  {31'd0, ract8},  {31'd0, ra});
        chk({tag, "_idx"},  {29'd0, ridx8},  ri);
        chk({tag, "_mode"}, {31'd0, rmode8}, {31'd0, m});
    endtask

    vec_t tv [9];
    vec_t sv [7];
    logic sv_v [7];
    exp_t se [7];
    exp_t q [$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv[0] = '{n:'{-1,-2,5,3,-128,127,0,7}, a:8'b1101_1111,
                  m:1'b0, r:7, ra:1'b1, ri:7};
        tv[1] = '{n:'{-1,-2,5,3,-128,127,0,7}, a:8'b1101_1111,
                  m:1'b1, r:-128, ra:1'b1, ri:4};
        tv[2] = '{n:'{3,3,3,3,3,3,3,3}, a:8'b0110_0000,
                  m:1'b0, r:3, ra:1'b1, ri:5};
        tv[3] = '{n:'{3,3,3,3,3,3,3,3}, a:8'b0110_0000,
                  m:1'b1, r:3, ra:1'b1, ri:5};
        tv[4] = '{n:'{9,-9,44,-77,1,2,3,4}, a:8'h00,
                  m:1'b0, r:0, ra:1'b0, ri:0};
        tv[5] = '{n:'{10,20,-2,30,40,50,60,70}, a:8'b0000_0100,
                  m:1'b0, r:-2, ra:1'b1, ri:2};
        tv[6] = '{n:'{0,1,2,3,4,127,-5,127}, a:8'hFF,
                  m:1'b0, r:127, ra:1'b1, ri:5};
        tv[7] = '{n:'{5,-1,0,-128,100,2,-128,-3}, a:8'hFF,
                  m:1'b1, r:-128, ra:1'b1, ri:3};
        tv[8] = '{n:'{100,100,100,100,100,100,100,-128},
                  a:8'b1000_0000, m:1'b0, r:-128, ra:1'b1, ri:7};

        in_valid8 = 1'b0;
        mode8     = 1'b0;
        numbers8  = '0;
        act8      = '0;
        in_valid5 = 1'b0;
        mode5     = 1'b0;
        numbers5  = '0;
        act5      = '0;

        // Asynchronous reset with no clock edge involved.
        #1 reset = 1'b1;
        #1;
        chk("rst0_ov",   {31'd0, ov8},    0);
        chk("rst0_res",  {24'd0, res8},   0);
        chk("rst0_act",  {31'd0, ract8},  0);
        chk("rst0_idx",  {29'd0, ridx8},  0);
        chk("rst0_mode", {31'd0, rmode8}, 0);
        chk("rst0_ov5",  {31'd0, ov5},    0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed table, each vector isolated to check latency.
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            drive8(tv[k].n, tv[k].a, tv[k].m);
            @(negedge clk);
            in_valid8 = 1'b0;
            // Off-edge input churn must not matter.
            numbers8  = {$urandom, $urandom};
            act8      = 8'($urandom);
            mode8     = ~mode8;
            chk($sformatf("v%0d_early1", k), {31'd0, ov8}, 0);
            @(negedge clk);
            chk($sformatf("v%0d_early2", k), {31'd0, ov8}, 0);
            @(negedge clk);
            chk8($sformatf("v%0d", k), tv[k].r, tv[k].ra,
                 tv[k].ri, tv[k].m);
        end

        // Streaming: modes 0,1,0,1, bubble, 2 more vectors.
        for (int s = 0; s < 7; s++) begin
            for (int i = 0; i < 8; i++)
                sv[s].n[i] = int'($urandom_range(0, 6)) - 3;
            sv[s].a  = 8'($urandom);
            sv[s].m  = s[0];
            sv_v[s]  = (s != 4);
            se[s].v  = sv_v[s];
            se[s].m  = sv[s].m;
            model(sv[s].n, 8, sv[s].a, sv[s].m,
                  se[s].r, se[s].ra, se[s].ri);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                if (se[c-3].v)
                    chk8($sformatf("st%0d", c - 3), se[c-3].r,
                         se[c-3].ra, se[c-3].ri, se[c-3].m);
                else
                    chk("st_bubble_ov", {31'd0, ov8}, 0);
            end
            if (c < 7 && sv_v[c])
                drive8(sv[c].n, sv[c].a, sv[c].m);
            else
                in_valid8 = 1'b0;
        end
        @(negedge clk);
        chk("st_drain_ov", {31'd0, ov8}, 0);

        // Mid-stream reset with a full pipeline.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive8(tv[1].n, tv[1].a, tv[1].m);
        end
        @(negedge clk);
        chk8("pre_rst", tv[1].r, tv[1].ra, tv[1].ri, tv[1].m);
        #2 reset = 1'b1;
        #1;
        chk("mrst_ov",   {31'd0, ov8},    0);
        chk("mrst_res",  {24'd0, res8},   0);
        chk("mrst_act",  {31'd0, ract8},  0);
        chk("mrst_idx",  {29'd0, ridx8},  0);
        chk("mrst_mode", {31'd0, rmode8}, 0);
        @(negedge clk);
        in_valid8 = 1'b0;
        reset     = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_ov%0d", c), {31'd0, ov8}, 0);
        end
        drive8(tv[0].n, tv[0].a, tv[0].m);
        @(negedge clk);
        in_valid8 = 1'b0;
        chk("post_rst_lat1", {31'd0, ov8}, 0);
        @(negedge clk);
        chk("post_rst_lat2", {31'd0, ov8}, 0);
        @(negedge clk);
        chk8("post_rst", tv[0].r, tv[0].ra, tv[0].ri, tv[0].m);

        // Odd size: 5 x 4-bit, 2000 random vectors with bubbles.
        begin
            int   sent;
            int   nv [8];
            exp_t e;
            exp_t g;
            sent = 0;
            for (int c = 0; c < 2200; c++) begin
                @(negedge clk);
                if (q.size() == 3) begin
                    g = q.pop_front();
                    chk("o5_ov", {31'd0, ov5}, {31'd0, g.v});
                    if (g.v) begin
                        chk("o5_act",  {31'd0, ract5},  {31'd0, g.ra});
                        chk("o5_res",  $signed(res5),   g.r);
                        chk("o5_idx",  {29'd0, ridx5},  g.ri);
                        chk("o5_mode", {31'd0, rmode5}, {31'd0, g.m});
                        if (ract5)
                            chk("o5_idx_rng",
                                {31'd0, (ridx5 < 3'd5)}, 1);
                    end
                end
                if (sent < 2000 && (c % 16) != 15) begin
                    for (int i = 0; i < 8; i++)
                        nv[i] = (i < 5) ?
                            int'($urandom_range(0, 15)) - 8 : 0;
                    for (int i = 0; i < 5; i++)
                        numbers5[i*4 +: 4] = 4'(nv[i]);
                    act5      = 5'($urandom);
                    if ($urandom_range(0, 9) == 0)
                        act5 = '0;
                    mode5     = 1'($urandom);
                    in_valid5 = 1'b1;
                    e.v = 1'b1;
                    e.m = mode5;
                    model(nv, 5, {3'b000, act5}, mode5,
                          e.r, e.ra, e.ri);
                    sent++;
                end else begin
                    in_valid5 = 1'b0;
                    numbers5  = 20'($urandom);
                    e.v  = 1'b0;
                    e.m  = 1'b0;
                    e.r  = 0;
                    e.ra = 1'b0;
                    e.ri = 0;
                end
                q.push_back(e);
            end
            chk("o5_sent", sent, 2000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/extremum_tree.md
# extremum_tree

Pipelined, parametrised min/max reduction over NUM_INPUTS signed candidates, each with its own activation flag. This is the multi-input successor to the two-input activation-aware comparator. It sits between the constraint-evaluation layer and the sampler and accepts one candidate vector per clock. Each cycle it selects the maximum or minimum active candidate, chosen per vector by `mode`, and reports its value, source index and a result-activation flag.

## Interface
Parameters:
- `WIDTH`, 8: bit width of each signed two's-complement candidate.
- `NUM_INPUTS`, 8: number of candidates, at least 2. Any value is legal; internally the set is padded to P = 2^ceil(log2(NUM_INPUTS)) with inactive entries.
- `IDX_W`, derived as ceil(log2(NUM_INPUTS)), minimum 1: width of the index output.

Ports:
- `clk` input, 1: rising-edge clock.
- `reset` input, 1: asynchronous reset, active-high.
- `in_valid` input, 1: the candidate vector on this cycle is to be processed.
- `mode` input, 1: 0 selects maximum, 1 selects minimum. Sampled with `in_valid`.
- `numbers` input, NUM_INPUTS*WIDTH: candidate i occupies bits [i*WIDTH +: WIDTH].
- `activations` input, NUM_INPUTS: bit i set means candidate i takes part in the comparison.
- `out_valid` output, 1: result outputs are valid this cycle.
- `result` output, WIDTH: signed extremum.
- `result_activation` output, 1: at least one candidate was active.
- `result_index` output, IDX_W: index of the winning candidate.
- `result_mode` output, 1: the `mode` that produced this result.

## Operation
- Binary reduction tree with L = ceil(log2(NUM_INPUTS)) levels and one register stage per level. No stage is combinational-only at the output.
- Each tree node carries four items: value (WIDTH bits, signed), act (1 bit), idx (IDX_W bits) and mode (travels with the data).
- Node rule for left child a (lower index) and right child b:
  - Both active, max mode: pick b only if b > a (signed compare); otherwise pick a.
  - Both active, min mode: pick b only if b < a; otherwise pick a.
  - A tie always goes to the lower index.
  - Exactly one child active: pick the active child.
  - Neither active: act=0, value=0, idx=0.
- Padded leaves (index ≥ NUM_INPUTS) are permanently inactive.
- Comparison is full-width signed. No saturation or truncation is applied, and `result` is always the exact value of some input candidate, or 0 when `result_activation`=0.
- `valid` shifts down the pipeline alongside the data.
- Stages holding valid=0 may keep stale data, but `out_valid`=0 is then guaranteed.
- When `out_valid`=0, the values on `result`, `result_index` and `result_mode` are don't-care. They must still be driven, never X after reset.
- No backpressure. Throughput is one vector per clock, and back-to-back vectors with different `mode` values are processed independently.

## Timing
- Latency: a vector sampled at edge k (with `in_valid`=1) appears with `out_valid`=1 during the cycle after edge k+L-1, that is, L cycles later.
  - NUM_INPUTS=8 gives L=3.
  - NUM_INPUTS=2 gives L=1.
  - NUM_INPUTS=5 gives L=3.
- Reset (asynchronous, immediate) sets:
  - all stage valid bits to 0, so `out_valid`=0
  - `result`=0
  - `result_activation`=0
  - `result_index`=0
  - `result_mode`=0
- Reset asserted mid-stream discards every in-flight vector. After deassertion the first `out_valid` appears exactly L cycles after the first accepted vector.
- A vector with `in_valid`=0 produces no output slot: a bubble propagates and `out_valid`=0 for that cycle.
- A valid vector with all activations at 0 still yields `out_valid`=1 with `result_activation`=0, `result`=0 and `result_index`=0.
- All inputs are sampled only at `clk` rising edges. Changes between edges have no effect.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle with the pipeline full.
  - Required: all outputs are 0 immediately, and no stale `out_valid` appears after release.
- Max, NUM_INPUTS=8, WIDTH=8: numbers {-1,-2,5,3,-128,127,0,7} with activations 8'b1101_1111 (bit 5 inactive), mode=0.
  - Required: after 3 cycles, `result`=7, `result_index`=7, `result_activation`=1.
- Min, same vector, mode=1.
  - Required: `result`=-128, `result_index`=4.
  - Ties: numbers all 3 with activations 8'b0110_0000 gives `result`=3, `result_index`=5.
- Inactive handling: activations=0 with any numbers, mode=0.
  - Required: `out_valid`=1, `result_activation`=0, `result`=0, `result_index`=0.
  - Single active bit 2 with value -2 gives `result`=-2, `result_index`=2.
- Streaming: 4 consecutive vectors with alternating `mode` (0,1,0,1), then a one-cycle `in_valid`=0 bubble, then 2 more vectors.
  - Required: outputs appear in order with matching `result_mode`, the bubble shows as `out_valid`=0 for exactly one cycle, and results match a reference model.
- Odd size: NUM_INPUTS=5, WIDTH=4, 2000 random vectors.
  - Required: latency is 3, padded entries never win, `result_index` < 5 whenever `result_activation`=1, and every result matches the scoreboard.
